fifo_level: RTL and testbench

- Parametrised successor to the team's basic synchronous FIFO (register-file storage plus pointer controller).
- Adds:
  - full-depth occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow error flags
  - synchronous flush
  - selectable read mode: show-ahead, or registered with a valid strobe
- Sits between byte producers and consumers (UART/keypad/crypto datapath) where software or an FSM needs level information and error visibility.

---
 rtl/fifo_level.sv | 103 ++++++++++
 tb/tb_fifo_level.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO with occupancy count, programmable almost
// flags, sticky overflow/underflow, synchronous flush and a choice of
// show-ahead or registered read data.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH-2,
  parameter int AE_LEVEL   = 2,
  parameter int SHOW_AHEAD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  ovf;
  logic                  udf;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come only from the registered count, so rd/wr never reach them
  // combinationally.
  assign count        = cnt;
  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_CNT);
  assign almost_empty = (cnt <= AE_CNT);
  assign almost_full  = (cnt >= AF_CNT);
  assign overflow     = ovf;
  assign underflow    = udf;

  // A flush or reset cycle accepts nothing; otherwise full/empty gate the
  // request independently of what the other port does this cycle.
  assign wr_acc = wr & ~full  & ~clr & ~reset;
  assign rd_acc = rd & ~empty & ~clr & ~reset;

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      if (wr_acc && !rd_acc)      cnt <= cnt + 1'b1;
      else if (rd_acc && !wr_acc) cnt <= cnt - 1'b1;
      if (wr && full)  ovf <= 1'b1;
      if (rd && empty) udf <= 1'b1;
    end
  end

  // Storage array; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= w_data;
  end

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign r_data  = mem[r_ptr];
    assign r_valid = ~empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] r_data_p1;
    logic                  vld_p1;

    // Stage p1: capture the head word on an accepted read; data holds
    // between reads, the strobe lasts one cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_data_p1 <= '0;
        vld_p1    <= 1'b0;
      end else begin
        vld_p1 <= rd_acc;
        if (rd_acc) r_data_p1 <= mem[r_ptr];
      end
    end

    assign r_data  = r_data_p1;
    assign r_valid = vld_p1;
  end

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: a show-ahead and a registered instance share one
// stimulus stream; a queue-based model predicts occupancy, flags and data.
module tb_fifo_level;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;

  logic [7:0] r_data_sa, r_data_rg;
  logic       r_valid_sa, r_valid_rg;
  logic       empty_sa, full_sa, ae_sa, af_sa, ovf_sa, udf_sa;
  logic       empty_rg, full_rg, ae_rg, af_rg, ovf_rg, udf_rg;
  logic [2:0] count_sa, count_rg;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  logic [7:0] mq[$];
  logic [7:0] exp_sa[$];
  logic [7:0] exp_rg[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always #5 clk = ~clk;

  fifo_level #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1),
               .SHOW_AHEAD(1)) u_sa (
    .clk(clk), .reset(reset), .clr(clr), .rd(rd), .wr(wr), .w_data(w_data),
    .r_data(r_data_sa), .r_valid(r_valid_sa), .empty(empty_sa), .full(full_sa),
    .almost_empty(ae_sa), .almost_full(af_sa), .count(count_sa),
    .overflow(ovf_sa), .underflow(udf_sa));

  fifo_level #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1),
               .SHOW_AHEAD(0)) u_rg (
    .clk(clk), .reset(reset), .clr(clr), .rd(rd), .wr(wr), .w_data(w_data),
    .r_data(r_data_rg), .r_valid(r_valid_rg), .empty(empty_rg), .full(full_rg),
    .almost_empty(ae_rg), .almost_full(af_rg), .count(count_rg),
    .overflow(ovf_rg), .underflow(udf_rg));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances on the same edge as the DUTs.
  task automatic step(input bit r, input bit w, input bit c, input bit rs,
                      input logic [7:0] d);
    bit m_full, m_empty;
    rd = r; wr = w; clr = c; reset = rs; w_data = d;
    if (!rs && !c && r && mq.size() != 0) begin
      exp_sa.push_back(mq[0]);
      exp_rg.push_back(mq[0]);
    end
    @(posedge clk);
    if (rs || c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      m_empty = (mq.size() == 0);
      if (w && m_full)  m_ovf = 1'b1;
      if (r && m_empty) m_udf = 1'b1;
      if (r && !m_empty) void'(mq.pop_front());
      if (w && !m_full)  mq.push_back(d);
    end
    #1;
  endtask

  // Monitor: status against the model every cycle, read data whenever a
  // DUT presents a word.
  always @(negedge clk) begin
    if (run) begin
      int n;
      n = mq.size();
      chk("count_sa", int'(count_sa), n);
      chk("count_rg", int'(count_rg), n);
      chk("empty", {empty_sa, empty_rg}, {2{n == 0}});
      chk("full", {full_sa, full_rg}, {2{n == DEPTH}});
      chk("almost_empty", {ae_sa, ae_rg}, {2{n <= 1}});
      chk("almost_full", {af_sa, af_rg}, {2{n >= 3}});
      chk("overflow", {ovf_sa, ovf_rg}, {2{m_ovf}});
      chk("underflow", {udf_sa, udf_rg}, {2{m_udf}});
      chk("r_valid_sa", int'(r_valid_sa), int'(n != 0));
      if (rd && r_valid_sa && !clr && !reset) begin
        if (exp_sa.size() == 0) chk("sa_unexpected_read", 1, 0);
        else chk("r_data_sa", int'(r_data_sa), int'(exp_sa.pop_front()));
      end
      if (r_valid_rg) begin
        if (exp_rg.size() == 0) chk("rg_unexpected_valid", 1, 0);
        else chk("r_data_rg", int'(r_data_rg), int'(exp_rg.pop_front()));
      end
    end
  end

  initial begin
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    run = 1'b1;
    chk("reset_count", int'(count_sa), 0);
    chk("reset_empty", int'(empty_sa), 1);
    chk("reset_r_valid_rg", int'(r_valid_rg), 0);
    chk("reset_r_data_rg", int'(r_data_rg), 0);

    // Fill, then overflow.
    step(0, 1, 0, 0, 8'hA1);
    step(0, 1, 0, 0, 8'hA2);
    step(0, 1, 0, 0, 8'hA3);
    step(0, 1, 0, 0, 8'hA4);
    chk("plan_full", {full_sa, count_sa}, {1'b1, 3'd4});
    step(0, 1, 0, 0, 8'hA5);
    chk("plan_overflow", {ovf_sa, count_sa}, {1'b1, 3'd4});

    // Drain, then underflow.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'h00);
    chk("plan_drained", int'(empty_sa), 1);
    step(1, 0, 0, 0, 8'h00);
    chk("plan_underflow", {udf_sa, count_sa}, {1'b1, 3'd0});

    // Read+write while full: read wins, write rejected.
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'hB0 + 8'(i));
    step(1, 1, 0, 0, 8'h77);
    chk("plan_rdwr_full", {ovf_sa, count_sa}, {1'b1, 3'd3});

    // Steady state at count 2 across two pointer wraps.
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 8'hC0 + 8'(i));
    chk("plan_steady", int'(count_sa), 2);

    // Registered read latency.
    step(0, 0, 1, 0, 8'h00);
    step(0, 1, 0, 0, 8'h5C);
    step(1, 0, 0, 0, 8'h00);
    chk("plan_rg_valid", {r_valid_rg, r_data_rg}, {1'b1, 8'h5C});
    step(0, 0, 0, 0, 8'h00);
    chk("plan_rg_valid_drop", int'(r_valid_rg), 0);

    // Flush (then reset) with a concurrent write at count 3 with overflow.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'hD0 + 8'(i));
      step(1, 0, 0, 0, 8'h00);
      chk("plan_pre_clear", {ovf_sa, count_sa}, {1'b1, 3'd3});
      step(0, 1, (k == 0), (k == 1), 8'hEE);
      chk("plan_cleared", {empty_sa, ovf_sa, count_sa}, {1'b1, 1'b0, 3'd0});
      step(0, 1, 0, 0, 8'h11);
      step(1, 0, 0, 0, 8'h00);
    end

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0),
           8'($urandom));

    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    run = 1'b0;
    chk("sa_queue_drained", exp_sa.size(), 0);
    chk("rg_queue_drained", exp_rg.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
